// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: width calculation and depth legality checks.
package fifo_pkg;

   localparam int unsigned MIN_DEPTH = 2;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned rem;
      result = 0;
      rem    = (value > 0) ? value - 1 : 0;
      while (rem != 0) begin
         rem    = rem >> 1;
         result = result + 1;
      end
      return result;
   endfunction

   function automatic bit is_pow2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit depth_ok(input int unsigned value);
      return is_pow2(value) && (value >= MIN_DEPTH);
   endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer handshake bundle for sync_fifo_flex; master is the client, slave the FIFO.
interface sync_fifo_flex_if
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16
) ();

   localparam int unsigned CW = clog2(DEPTH) + 1;

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_regfile #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AW         = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with optional first-word-fall-through, threshold flags, exact count,
// synchronous flush and overflow/underflow pulses.
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned AF_THRESH  = 14,
   parameter int unsigned AE_THRESH  = 2
) (
   input logic             clk,
   input logic             rst,
   sync_fifo_flex_if.slave ff
);

   localparam int unsigned   AW     = clog2(DEPTH);
   localparam int unsigned   CW     = AW + 1;
   localparam logic [CW-1:0] AF_LIM = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_LIM = CW'(AE_THRESH);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flex: AF_THRESH out of range");
   end
   if (AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_flex: AE_THRESH out of range");
   end

   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_addr, rd_addr;
   logic [CW-1:0]         count;
   logic                  full, empty;
   logic                  wr_acc, rd_acc;
   logic                  overflow_q, underflow_q;
   logic [DATA_WIDTH-1:0] rdata;

   assign wr_addr = wr_ptr_q[AW-1:0];
   assign rd_addr = rd_ptr_q[AW-1:0];

   // Extra wrap bit distinguishes full from empty when the addresses coincide.
   assign full  = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign count = wr_ptr_q - rd_ptr_q;

   assign wr_acc = ff.wr_en & ~full  & ~ff.flush;
   assign rd_acc = ff.rd_en & ~empty & ~ff.flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (ff.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= ff.wr_en & full  & ~ff.flush;
         underflow_q <= ff.rd_en & empty & ~ff.flush;
      end
   end

   fifo_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_regfile (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_addr),
      .wdata (ff.din),
      .raddr (rd_addr),
      .rdata (rdata)
   );

   if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset reads back as 0.
      assign ff.dout = empty ? '0 : rdata;
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q <= '0;
         end else if (rd_acc) begin
            dout_q <= rdata;
         end
      end
      assign ff.dout = dout_q;
   end

   assign ff.full         = full;
   assign ff.empty        = empty;
   assign ff.almost_full  = (count >= AF_LIM);
   assign ff.almost_empty = (count <= AE_LIM);
   assign ff.count        = count;
   assign ff.overflow     = overflow_q;
   assign ff.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: registered-read FIFO against a queue scoreboard, plus an FWFT instance.
module tb_sync_fifo_flex;

   logic clk;
   logic rst;

   int n_cmp;
   int n_err;

   sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(16)) if0 ();
   sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(16)) if1 ();

   sync_fifo_flex #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .FWFT       (0),
      .AF_THRESH  (14),
      .AE_THRESH  (2)
   ) dut0 (
      .clk (clk),
      .rst (rst),
      .ff  (if0)
   );

   sync_fifo_flex #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .FWFT       (1),
      .AF_THRESH  (14),
      .AE_THRESH  (2)
   ) dut1 (
      .clk (clk),
      .rst (rst),
      .ff  (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard for dut0: words pushed on accepted writes, popped on accepted reads.
   logic [7:0] m_q[$];
   logic [7:0] m_dout;
   logic       m_ovf;
   logic       m_unf;

   typedef struct {
      logic       wr;
      logic [7:0] din;
      logic       rd;
      logic       fl;
      int         e_cnt;
      logic       e_empty;
      logic       e_ovf;
      logic       e_unf;
      logic [7:0] e_dout;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int sz;
      sz = m_q.size();
      chk("count", 32'(if0.count), 32'(sz));
      chk("full", 32'(if0.full), 32'(sz == 16));
      chk("empty", 32'(if0.empty), 32'(sz == 0));
      chk("almost_full", 32'(if0.almost_full), 32'(sz >= 14));
      chk("almost_empty", 32'(if0.almost_empty), 32'(sz <= 2));
      chk("overflow", 32'(if0.overflow), 32'(m_ovf));
      chk("underflow", 32'(if0.underflow), 32'(m_unf));
      chk("dout", 32'(if0.dout), 32'(m_dout));
   endtask

   task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
      int sz;
      @(negedge clk);
      if0.wr_en = wr;
      if0.din   = d;
      if0.rd_en = rd;
      if0.flush = fl;
      sz    = m_q.size();
      m_ovf = wr && (sz == 16) && !fl;
      m_unf = rd && (sz == 0) && !fl;
      if (fl) begin
         m_q.delete();
      end else begin
         if (rd && sz != 0) m_dout = m_q.pop_front();
         if (wr && sz != 16) m_q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic idle0();
      if0.wr_en = 1'b0;
      if0.rd_en = 1'b0;
      if0.flush = 1'b0;
      if0.din   = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      idle0();
      if1.wr_en = 1'b0;
      if1.rd_en = 1'b0;
      if1.flush = 1'b0;
      if1.din   = 8'h00;
      rst = 1'b1;

      //            wr    din    rd    fl    cnt empty ovf   unf   dout
      vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'h00};
      vecs[1] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b1, 8'hB2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA1};
      vecs[4] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hB2};
      vecs[5] = '{1'b1, 8'hD4, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hB2};
      vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hB2};
      vecs[7] = '{1'b1, 8'hE5, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'hB2};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hE5};

      // Reset state while rst is held
      #3;
      check_model();
      chk("fwft_rst_empty", 32'(if1.empty), 32'd1);
      chk("fwft_rst_dout", 32'(if1.dout), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven basic vectors
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl);
         chk($sformatf("vec%0d_count", i), 32'(if0.count), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d_empty", i), 32'(if0.empty), 32'(vecs[i].e_empty));
         chk($sformatf("vec%0d_ovf", i), 32'(if0.overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d_unf", i), 32'(if0.underflow), 32'(vecs[i].e_unf));
         chk($sformatf("vec%0d_dout", i), 32'(if0.dout), 32'(vecs[i].e_dout));
      end

      // Fill to full, then one write too many
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 12) chk("af_at_13", 32'(if0.almost_full), 32'd0);
         if (i == 13) chk("af_at_14", 32'(if0.almost_full), 32'd1);
      end
      chk("full_at_16", 32'(if0.full), 32'd1);
      step(1'b1, 8'h10, 1'b0, 1'b0);
      chk("ovf_pulse", 32'(if0.overflow), 32'd1);
      chk("count_after_ovf", 32'(if0.count), 32'd16);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_one_cycle", 32'(if0.overflow), 32'd0);

      // Drain, then one read too many
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("drain%0d", i), 32'(if0.dout), 32'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("unf_pulse", 32'(if0.underflow), 32'd1);
      chk("dout_hold", 32'(if0.dout), 32'h0F);

      // Steady simultaneous read/write at count 8 across pointer wrap
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      chk("stream_count", 32'(if0.count), 32'd8);

      // Flush with concurrent write at count 5
      step(1'b1, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b1);
      chk("flush_count", 32'(if0.count), 32'd0);
      chk("flush_ae", 32'(if0.almost_empty), 32'd1);
      chk("flush_no_ovf", 32'(if0.overflow), 32'd0);
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_roundtrip", 32'(if0.dout), 32'h3C);

      // FWFT instance: head word appears without a read
      @(negedge clk);
      if1.wr_en = 1'b1;
      if1.din   = 8'hA5;
      @(posedge clk);
      #1;
      chk("fwft_empty_after_wr", 32'(if1.empty), 32'd0);
      chk("fwft_dout_a5", 32'(if1.dout), 32'hA5);
      @(negedge clk);
      if1.wr_en = 1'b0;
      @(posedge clk);
      #1;
      chk("fwft_dout_held", 32'(if1.dout), 32'hA5);
      @(negedge clk);
      if1.rd_en = 1'b1;
      @(posedge clk);
      #1;
      chk("fwft_empty_after_rd", 32'(if1.empty), 32'd1);
      chk("fwft_count0", 32'(if1.count), 32'd0);
      @(negedge clk);
      if1.rd_en = 1'b0;
      if1.wr_en = 1'b1;
      if1.din   = 8'h11;
      @(negedge clk);
      if1.din   = 8'h22;
      @(negedge clk);
      if1.wr_en = 1'b0;
      chk("fwft_head1", 32'(if1.dout), 32'h11);
      if1.rd_en = 1'b1;
      @(posedge clk);
      #1;
      chk("fwft_head2", 32'(if1.dout), 32'h22);
      @(negedge clk);
      if1.rd_en = 1'b0;
      @(negedge clk);
      if1.rd_en = 1'b1;
      @(negedge clk);
      if1.rd_en = 1'b0;
      chk("fwft_drained", 32'(if1.empty), 32'd1);

      // Asynchronous reset in the middle of a burst at count 10
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(if0.count), 32'd10);
      @(negedge clk);
      idle0();
      rst = 1'b1;
      m_q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      #1;
      check_model();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_roundtrip", 32'(if0.dout), 32'h5A);
      idle0();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
